// File: rtl/sqrt_req_scheduler.sv
// Round-robin front end that shares one iterative square-root core among NUM_REQ requesters.
// Each job restarts the core with a one-cycle reset pulse and runs under a watchdog.
module sqrt_req_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ROOT_W  = DATA_W / 2,
    parameter int unsigned TIMEOUT = 300,
    localparam int unsigned ID_W   = $clog2(NUM_REQ),
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] operand_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      core_rst_n_o,
    output logic [DATA_W-1:0]         core_x_o,
    input  logic                      core_done_i,
    input  logic [ROOT_W-1:0]         core_root_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [ROOT_W-1:0]         rsp_root_o,
    output logic                      rsp_err_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]   wdog_q;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      pick_off;
    logic [ID_W:0]        pick_sum;
    logic [ID_W-1:0]      pick;
    logic                 found;
    logic [ID_W-1:0]      ptr_next;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        req_dbl  = {req_i, req_i} >> ptr_q;
        req_rot  = req_dbl[NUM_REQ-1:0];
        found    = 1'b0;
        pick_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found    = 1'b1;
                pick_off = ID_W'(i);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (ID_W + 1)'(NUM_REQ)) begin
            pick = ID_W'(pick_sum - (ID_W + 1)'(NUM_REQ));
        end else begin
            pick = pick_sum[ID_W-1:0];
        end
        ptr_next = (rsp_id_o == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_o + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            wdog_q      <= '0;
            gnt_o       <= '0;
            core_x_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_root_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        rsp_id_o <= pick;
                        gnt_o    <= NUM_REQ'(1) << pick;
                        core_x_o <= operand_i[pick*DATA_W +: DATA_W];
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    wdog_q  <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    wdog_q <= wdog_q + 1'b1;
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (core_done_i) begin
                        rsp_root_o  <= core_root_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state_q     <= StResp;
                    end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_root_o  <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        gnt_o       <= '0;
                        ptr_q       <= ptr_next;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

    // Core reset follows the block reset asynchronously and pulses low during LOAD.
    assign core_rst_n_o = rst_n & (state_q != StLoad);
    assign busy_o       = (state_q != StIdle);

endmodule
